// File: rtl/parity_frame_tx_if.sv
// Nibble handshake between the producer (master) and the framing transmitter (slave).
interface parity_frame_tx_if;
    logic [3:0] data_in;
    logic       data_valid;
    logic       data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/parity_frame_tx.sv
// Accepts a nibble and serializes start, b0..b3 (LSB first), even parity and stop bit(s).
module parity_frame_tx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    parity_frame_tx_if.slave   in_if,
    output logic               tx_out,
    output logic               busy,
    output logic               parity_out,
    output logic               frame_done
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    localparam logic [7:0] LAST_CNT  = 8'(CLKS_PER_BIT - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    state_e     state_q, state_d;
    logic [7:0] clk_cnt_q, clk_cnt_d;
    logic [1:0] bit_cnt_q, bit_cnt_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic [3:0] shift_q, shift_d;
    logic       tx_q, tx_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       parity_q, parity_d;
    logic       done_q, done_d;
    logic       bit_end;

    assign bit_end = (clk_cnt_q == LAST_CNT);

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        parity_d   = parity_q;
        done_d     = 1'b0;

        if (state_q != IDLE) begin
            clk_cnt_d = bit_end ? '0 : clk_cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (in_if.data_valid && ready_q) begin
                    shift_d   = in_if.data_in;
                    parity_d  = ^in_if.data_in;
                    state_d   = START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                    ready_d   = 1'b0;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                // Shift register keeps the next data bit at [1]; after b3 the parity bit follows.
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 2'd1;
                    if (bit_cnt_q == 2'd3) begin
                        state_d = PARITY;
                        tx_d    = parity_q;
                    end else begin
                        tx_d    = shift_q[1];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d    = IDLE;
                        busy_d     = 1'b0;
                        ready_d    = 1'b1;
                        done_d     = 1'b1;
                        stop_cnt_d = '0;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            parity_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            parity_q   <= parity_d;
            done_q     <= done_d;
        end
    end

    assign in_if.data_ready = ready_q;
    assign tx_out           = tx_q;
    assign busy             = busy_q;
    assign parity_out       = parity_q;
    assign frame_done       = done_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed bench for parity_frame_tx: default timing plus a CLKS_PER_BIT=1, STOP_BITS=2 instance.
module tb_parity_frame_tx;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic tx0, busy0, par0, done0;
    logic tx1, busy1, par1, done1;

    parity_frame_tx_if if0 ();
    parity_frame_tx_if if1 ();

    parity_frame_tx u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_if      (if0.slave),
        .tx_out     (tx0),
        .busy       (busy0),
        .parity_out (par0),
        .frame_done (done0)
    );

    parity_frame_tx #(.CLKS_PER_BIT(1), .STOP_BITS(2)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_if      (if1.slave),
        .tx_out     (tx1),
        .busy       (busy1),
        .parity_out (par1),
        .frame_done (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with u_dut0 idle; returns at the negedge of the frame_done cycle.
    task automatic send_check(input logic [3:0] d, input bit hold_valid, input logic [3:0] mid_d);
        logic [6:0] exp_bits;
        exp_bits = {1'b1, d[0] ^ d[1] ^ d[2] ^ d[3], d, 1'b0};
        check($sformatf("ready_idle_%0h", d), 8'(if0.data_ready), 8'h01);
        if0.data_in    = d;
        if0.data_valid = 1'b1;
        @(negedge clk);
        if (!hold_valid) if0.data_valid = 1'b0;
        check($sformatf("accept_%0h {rdy,busy,par}", d), 8'({if0.data_ready, busy0, par0}),
              8'({1'b0, 1'b1, exp_bits[5]}));
        for (int j = 0; j < 28; j++) begin
            if (j > 0) @(negedge clk);
            if (j == 10) if0.data_in = mid_d;
            check($sformatf("tx_%0h_c%0d {tx,done}", d, j), 8'({tx0, done0}),
                  8'({exp_bits[j / 4], 1'b0}));
        end
        @(negedge clk);
        check($sformatf("done_%0h {done,rdy,busy,tx,par}", d),
              8'({done0, if0.data_ready, busy0, tx0, par0}),
              8'({1'b1, 1'b1, 1'b0, 1'b1, exp_bits[5]}));
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        if0.data_in    = 4'h0;
        if0.data_valid = 1'b0;
        if1.data_in    = 4'h0;
        if1.data_valid = 1'b0;

        repeat (2) @(negedge clk);
        check("reset0 {tx,rdy,busy,par,done}", 8'({tx0, if0.data_ready, busy0, par0, done0}), 8'b0001_1000);
        check("reset1 {tx,rdy,busy,par,done}", 8'({tx1, if1.data_ready, busy1, par1, done1}), 8'b0001_1000);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame 1011, then frame_done drops after one cycle
        send_check(4'b1011, 1'b0, 4'b1011);
        @(negedge clk);
        check("done_pulse_width", 8'(done0), 8'h00);

        // Back-to-back with valid held: exactly one idle cycle between frames
        send_check(4'b0000, 1'b1, 4'b0000);
        send_check(4'b1111, 1'b0, 4'b1111);

        // Mid-frame data change is ignored; new nibble accepted after frame_done
        send_check(4'b0001, 1'b1, 4'b1110);
        send_check(4'b1110, 1'b0, 4'b1110);

        // Parity sweep over all nibbles
        for (int n = 0; n < 16; n++) begin
            send_check(4'(n), 1'b0, 4'(n));
        end

        // Reset during b2 of 1011 (b2 = 0, so the line visibly returns high)
        if0.data_in    = 4'b1011;
        if0.data_valid = 1'b1;
        @(negedge clk);
        if0.data_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("pre_reset_b2 {tx,busy}", 8'({tx0, busy0}), 8'b01);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset {tx,busy,rdy,done,par}", 8'({tx0, busy0, if0.data_ready, done0, par0}), 8'b1_0100);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("post_reset_c%0d {tx,busy,done}", k), 8'({tx0, busy0, done0}), 8'b100);
        end
        send_check(4'b0110, 1'b0, 4'b0110);

        // CLKS_PER_BIT=1, STOP_BITS=2, data 1000 -> 0,0,0,0,1,1,1,1
        if1.data_in    = 4'b1000;
        if1.data_valid = 1'b1;
        @(negedge clk);
        if1.data_valid = 1'b0;
        check("fast_accept {rdy,busy,par}", 8'({if1.data_ready, busy1, par1}), 8'b011);
        for (int j = 0; j < 8; j++) begin
            logic [7:0] exp_fast;
            exp_fast = 8'b1111_0000;
            if (j > 0) @(negedge clk);
            check($sformatf("fast_tx_c%0d {tx,done}", j), 8'({tx1, done1}), 8'({exp_fast[j], 1'b0}));
        end
        @(negedge clk);
        check("fast_done {done,rdy,busy,tx}", 8'({done1, if1.data_ready, busy1, tx1}), 8'b1101);
        @(negedge clk);
        check("fast_done_drop", 8'(done1), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
